step_down_counter: RTL

STEP_DOWN_COUNTER -- requirements
Module: step_down_counter

---
 rtl/step_down_counter_pkg.sv | 11 +
 rtl/step_down_counter.sv | 80 ++++++++
 2 files changed

// File: rtl/step_down_counter_pkg.sv
// Shared constants for the step-down counter: FSM state encoding.
package step_down_counter_pkg;

  // Explicit codes; 2'b11 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/step_down_counter.sv
// Loadable down-counter with terminal-count pulse.
//
//   state | meaning
//   ------+-----------------------------------------------------
//   IDLE  | waiting for a load; c_down ignored, out holds
//   RUN   | counting down on c_down, stalls while c_down=0
//   DONE  | one-cycle terminal-count pulse, then back to IDLE
//
// A load always wins over c_down. A zero load goes straight to DONE so
// that every load produces exactly one done pulse.
module step_down_counter
  import step_down_counter_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         c_down,
  output logic [W-1:0] out,
  output logic         zero,
  output logic         busy,
  output logic         done
);

  state_t         state_q;
  state_t         state_d;
  logic [W-1:0]   cnt_d;

  // State and count registers; async reset aborts any count in progress.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      out     <= '0;
    end else begin
      state_q <= state_d;
      out     <= cnt_d;
    end
  end

  // Next state and next count.
  always_comb begin
    state_d = IDLE;
    cnt_d   = out;
    if (ld) begin
      cnt_d   = ld_val;
      state_d = (ld_val == '0) ? DONE : RUN;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        RUN: begin
          if (c_down) begin
            // out <= 1 in RUN terminates; the <=1 guard also keeps a
            // corrupted zero from wrapping to all-ones.
            if (out > W'(1)) begin
              cnt_d   = out - W'(1);
              state_d = RUN;
            end else begin
              cnt_d   = '0;
              state_d = DONE;
            end
          end else begin
            state_d = RUN;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Moore outputs decoded from registered state and count only.
  always_comb begin
    zero = (out == '0);
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

endmodule
